// File: rtl/logic_axi4_lite_arbiter_if.sv
// AXI4-Lite bundle with PORTS parallel lanes; lane i occupies slice i of every vector.
// Use PORTS=SLAVES for the upstream requesters and PORTS=1 for the shared downstream port.
interface logic_axi4_lite_arbiter_if #(
  parameter int PORTS         = 1,
  parameter int DATA_BYTES    = 4,
  parameter int ADDRESS_WIDTH = 1
);
  logic [PORTS-1:0]                 awvalid;
  logic [PORTS-1:0]                 awready;
  logic [PORTS*ADDRESS_WIDTH-1:0]   awaddr;
  logic [PORTS*3-1:0]               awprot;
  logic [PORTS-1:0]                 wvalid;
  logic [PORTS-1:0]                 wready;
  logic [PORTS*8*DATA_BYTES-1:0]    wdata;
  logic [PORTS*DATA_BYTES-1:0]      wstrb;
  logic [PORTS-1:0]                 bvalid;
  logic [PORTS-1:0]                 bready;
  logic [PORTS*2-1:0]               bresp;
  logic [PORTS-1:0]                 arvalid;
  logic [PORTS-1:0]                 arready;
  logic [PORTS*ADDRESS_WIDTH-1:0]   araddr;
  logic [PORTS*3-1:0]               arprot;
  logic [PORTS-1:0]                 rvalid;
  logic [PORTS-1:0]                 rready;
  logic [PORTS*8*DATA_BYTES-1:0]    rdata;
  logic [PORTS*2-1:0]               rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/logic_axi4_lite_arbiter.sv
// Round-robin AXI4-Lite arbiter: SLAVES requesters share one downstream port, one
// outstanding transaction per path, 1 arbitration cycle, backpressure passed straight through.
module logic_axi4_lite_arbiter #(
  parameter int SLAVES        = 2,
  parameter int DATA_BYTES    = 4,
  parameter int ADDRESS_WIDTH = 1
) (
  input  logic                            aclk,
  input  logic                            areset,
  logic_axi4_lite_arbiter_if.slave        slave_io,
  logic_axi4_lite_arbiter_if.master       master_io
);
  localparam int DW    = 8 * DATA_BYTES;
  localparam int IDX_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST = idx_t'(SLAVES - 1);

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;

  // First requester found walking upward from ptr, wrapping at SLAVES-1.
  function automatic idx_t rr_pick(input logic [SLAVES-1:0] req, input idx_t ptr);
    idx_t idx;
    idx_t pick;
    logic found;
    idx   = ptr;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < SLAVES; k++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
      idx = (idx == LAST) ? '0 : idx + idx_t'(1);
    end
    return pick;
  endfunction

  function automatic idx_t rr_next(input idx_t g);
    return (g == LAST) ? '0 : g + idx_t'(1);
  endfunction

  wr_state_e wr_state_q, wr_state_d;
  idx_t      wr_grant_q, wr_grant_d, wr_ptr_q, wr_ptr_d;
  logic      aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic      aw_hs, w_hs;
  rd_state_e rd_state_q, rd_state_d;
  idx_t      rd_grant_q, rd_grant_d, rd_ptr_q, rd_ptr_d;

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state_q <= W_IDLE;
      wr_grant_q <= '0;
      wr_ptr_q   <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rd_state_q <= R_IDLE;
      rd_grant_q <= '0;
      rd_ptr_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_grant_q <= wr_grant_d;
      wr_ptr_q   <= wr_ptr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rd_state_q <= rd_state_d;
      rd_grant_q <= rd_grant_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Write path: AW and W may finish in either order; each is masked once done.
  always_comb begin
    wr_state_d       = wr_state_q;
    wr_grant_d       = wr_grant_q;
    wr_ptr_d         = wr_ptr_q;
    aw_done_d        = aw_done_q;
    w_done_d         = w_done_q;
    aw_hs            = 1'b0;
    w_hs             = 1'b0;
    master_io.awvalid = 1'b0;
    master_io.awaddr  = slave_io.awaddr[wr_grant_q*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    master_io.awprot  = slave_io.awprot[wr_grant_q*3 +: 3];
    master_io.wvalid  = 1'b0;
    master_io.wdata   = slave_io.wdata[wr_grant_q*DW +: DW];
    master_io.wstrb   = slave_io.wstrb[wr_grant_q*DATA_BYTES +: DATA_BYTES];
    master_io.bready  = 1'b0;
    slave_io.awready  = '0;
    slave_io.wready   = '0;
    slave_io.bvalid   = '0;
    slave_io.bresp    = '0;
    case (wr_state_q)
      W_IDLE: begin
        if (|(slave_io.awvalid | slave_io.wvalid)) begin
          wr_grant_d = rr_pick(slave_io.awvalid | slave_io.wvalid, wr_ptr_q);
          wr_state_d = W_REQ;
        end
      end
      W_REQ: begin
        master_io.awvalid            = slave_io.awvalid[wr_grant_q] & ~aw_done_q;
        slave_io.awready[wr_grant_q] = master_io.awready[0] & ~aw_done_q;
        master_io.wvalid             = slave_io.wvalid[wr_grant_q] & ~w_done_q;
        slave_io.wready[wr_grant_q]  = master_io.wready[0] & ~w_done_q;
        aw_hs     = slave_io.awvalid[wr_grant_q] & ~aw_done_q & master_io.awready[0];
        w_hs      = slave_io.wvalid[wr_grant_q] & ~w_done_q & master_io.wready[0];
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) wr_state_d = W_RESP;
      end
      W_RESP: begin
        slave_io.bvalid[wr_grant_q]       = master_io.bvalid[0];
        slave_io.bresp[wr_grant_q*2 +: 2] = master_io.bresp;
        master_io.bready                  = slave_io.bready[wr_grant_q];
        if (master_io.bvalid[0] && slave_io.bready[wr_grant_q]) begin
          wr_ptr_d   = rr_next(wr_grant_q);
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d        = rd_state_q;
    rd_grant_d        = rd_grant_q;
    rd_ptr_d          = rd_ptr_q;
    master_io.arvalid = 1'b0;
    master_io.araddr  = slave_io.araddr[rd_grant_q*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    master_io.arprot  = slave_io.arprot[rd_grant_q*3 +: 3];
    master_io.rready  = 1'b0;
    slave_io.arready  = '0;
    slave_io.rvalid   = '0;
    slave_io.rdata    = '0;
    slave_io.rresp    = '0;
    case (rd_state_q)
      R_IDLE: begin
        if (|slave_io.arvalid) begin
          rd_grant_d = rr_pick(slave_io.arvalid, rd_ptr_q);
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        master_io.arvalid            = slave_io.arvalid[rd_grant_q];
        slave_io.arready[rd_grant_q] = master_io.arready[0];
        if (slave_io.arvalid[rd_grant_q] && master_io.arready[0]) rd_state_d = R_DATA;
      end
      R_DATA: begin
        slave_io.rvalid[rd_grant_q]        = master_io.rvalid[0];
        slave_io.rdata[rd_grant_q*DW +: DW] = master_io.rdata;
        slave_io.rresp[rd_grant_q*2 +: 2]  = master_io.rresp;
        master_io.rready                   = slave_io.rready[rd_grant_q];
        if (master_io.rvalid[0] && slave_io.rready[rd_grant_q]) begin
          rd_ptr_d   = rr_next(rd_grant_q);
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end
endmodule

// File: tb/tb_logic_axi4_lite_arbiter.sv
// Directed bench: two requesters and a one-deep target model, all driven from one process.
module tb_logic_axi4_lite_arbiter;
  localparam int N  = 2;
  localparam int DB = 4;
  localparam int AW = 1;

  logic aclk;
  logic areset;

  logic_axi4_lite_arbiter_if #(.PORTS(N), .DATA_BYTES(DB), .ADDRESS_WIDTH(AW)) up_if ();
  logic_axi4_lite_arbiter_if #(.PORTS(1), .DATA_BYTES(DB), .ADDRESS_WIDTH(AW)) dn_if ();

  logic_axi4_lite_arbiter #(.SLAVES(N), .DATA_BYTES(DB), .ADDRESS_WIDTH(AW)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .slave_io  (up_if),
    .master_io (dn_if)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int leak  = 0;
  int b_cnt [N];
  int r_cnt [N];
  logic [31:0] last_rdata [N];
  int aw_order [$];
  int ar_order [$];
  int b_order  [$];
  int tgt_aw_cnt = 0;
  int tgt_w_cnt  = 0;

  logic [N-1:0] s_aw, s_w, s_b, s_ar, s_r;
  logic [31:0]  crd [N];
  logic t_aw, t_w, t_b, t_ar, t_r, t_rst, t_addr, pend_aw, pend_w;

  logic [14:0] all_hs;
  assign all_hs = {dn_if.awvalid, dn_if.wvalid, dn_if.bready, dn_if.arvalid, dn_if.rready,
                   up_if.awready, up_if.wready, up_if.bvalid, up_if.arready, up_if.rvalid};

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then update requesters and target after the edge.
  task automatic cyc();
    @(negedge aclk);
    s_aw = up_if.awvalid & up_if.awready;
    s_w  = up_if.wvalid  & up_if.wready;
    s_b  = up_if.bvalid  & up_if.bready;
    s_ar = up_if.arvalid & up_if.arready;
    s_r  = up_if.rvalid  & up_if.rready;
    for (int i = 0; i < N; i++) begin
      crd[i] = up_if.rdata[i*32 +: 32];
      if (!up_if.rvalid[i] && (crd[i] != 32'h0 || up_if.rresp[i*2 +: 2] != 2'b00)) leak++;
      if (!up_if.bvalid[i] && up_if.bresp[i*2 +: 2] != 2'b00) leak++;
    end
    t_aw   = dn_if.awvalid[0] & dn_if.awready[0];
    t_w    = dn_if.wvalid[0]  & dn_if.wready[0];
    t_b    = dn_if.bvalid[0]  & dn_if.bready[0];
    t_ar   = dn_if.arvalid[0] & dn_if.arready[0];
    t_r    = dn_if.rvalid[0]  & dn_if.rready[0];
    t_addr = dn_if.araddr[0];
    t_rst  = areset;
    @(posedge aclk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (s_aw[i]) begin up_if.awvalid[i] = 1'b0; aw_order.push_back(i); end
      if (s_w[i])  up_if.wvalid[i] = 1'b0;
      if (s_ar[i]) begin up_if.arvalid[i] = 1'b0; ar_order.push_back(i); end
      if (s_b[i])  begin b_cnt[i]++; b_order.push_back(i); end
      if (s_r[i])  begin r_cnt[i]++; last_rdata[i] = crd[i]; end
    end
    if (t_rst) begin
      dn_if.bvalid = 1'b0;
      dn_if.rvalid = 1'b0;
      dn_if.rdata  = '0;
      pend_aw = 1'b0;
      pend_w  = 1'b0;
    end else begin
      if (t_aw) begin pend_aw = 1'b1; tgt_aw_cnt++; end
      if (t_w)  begin pend_w = 1'b1; tgt_w_cnt++; end
      if (t_b)  dn_if.bvalid = 1'b0;
      if (pend_aw && pend_w && !dn_if.bvalid[0]) begin
        dn_if.bvalid = 1'b1;
        dn_if.bresp  = 2'b00;
        pend_aw = 1'b0;
        pend_w  = 1'b0;
      end
      if (t_r) begin dn_if.rvalid = 1'b0; dn_if.rdata = '0; end
      if (t_ar) begin
        dn_if.rvalid = 1'b1;
        dn_if.rdata  = t_addr ? 32'hCAFEF00D : 32'h12345678;
      end
    end
    #1;
  endtask

  task automatic wr_req(input int p, input logic a, input logic [31:0] d, input logic [3:0] s,
                        input logic do_aw, input logic do_w);
    up_if.awaddr[p]          = a;
    up_if.awprot[p*3 +: 3]   = 3'b010;
    up_if.wdata[p*32 +: 32]  = d;
    up_if.wstrb[p*4 +: 4]    = s;
    if (do_aw) up_if.awvalid[p] = 1'b1;
    if (do_w)  up_if.wvalid[p]  = 1'b1;
  endtask

  task automatic rd_req(input int p, input logic a);
    up_if.araddr[p]        = a;
    up_if.arprot[p*3 +: 3] = 3'b000;
    up_if.arvalid[p]       = 1'b1;
  endtask

  task automatic wait_b(input int p, input int target, input string tag);
    for (int k = 0; k < 200 && b_cnt[p] < target; k++) cyc();
    chk(tag, b_cnt[p], target);
  endtask

  task automatic wait_r(input int p, input int target, input string tag);
    for (int k = 0; k < 200 && r_cnt[p] < target; k++) cyc();
    chk(tag, r_cnt[p], target);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      b_cnt[i] = 0;
      r_cnt[i] = 0;
      last_rdata[i] = '0;
    end
    pend_aw = 1'b0;
    pend_w  = 1'b0;
    areset = 1'b1;
    up_if.awvalid = '0; up_if.awaddr = '0; up_if.awprot = '0;
    up_if.wvalid  = '0; up_if.wdata  = '0; up_if.wstrb  = '0;
    up_if.bready  = '1;
    up_if.arvalid = '0; up_if.araddr = '0; up_if.arprot = '0;
    up_if.rready  = '1;
    dn_if.awready = 1'b1; dn_if.wready = 1'b1; dn_if.arready = 1'b1;
    dn_if.bvalid  = 1'b0; dn_if.bresp  = 2'b00;
    dn_if.rvalid  = 1'b0; dn_if.rdata  = '0; dn_if.rresp = 2'b00;

    cyc();
    cyc();
    chk("rst_outs", all_hs, 15'h0);
    areset = 1'b0;

    // Single write from port 1.
    wr_req(1, 1'b1, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1);
    chk("t1_arb_cycle", dn_if.awvalid, 1'b0);
    cyc();
    chk("t1_m_valids", {dn_if.awvalid, dn_if.wvalid}, 2'b11);
    chk("t1_m_awaddr", dn_if.awaddr, 1'b1);
    chk("t1_m_wdata", dn_if.wdata, 32'hDEADBEEF);
    chk("t1_m_wstrb", dn_if.wstrb, 4'hF);
    chk("t1_s_awready", up_if.awready, 2'b10);
    cyc();
    chk("t1_s_bvalid", up_if.bvalid, 2'b10);
    chk("t1_s_bresp", up_if.bresp, 4'h0);
    cyc();
    chk("t1_b_cnt1", b_cnt[1], 1);
    chk("t1_b_cnt0", b_cnt[0], 0);
    chk("t1_bvalid_low", up_if.bvalid, 2'b00);
    chk("t1_tgt_aw", tgt_aw_cnt, 1);

    // Both ports request together; port 0 re-requests while port 1 is pending.
    aw_order.delete();
    b_order.delete();
    wr_req(0, 1'b0, 32'h11111111, 4'hF, 1'b1, 1'b1);
    wr_req(1, 1'b1, 32'h22222222, 4'h3, 1'b1, 1'b1);
    wait_b(0, 1, "t2_b0_first");
    wr_req(0, 1'b0, 32'h33333333, 4'hF, 1'b1, 1'b1);
    wait_b(1, 2, "t2_b1");
    wait_b(0, 2, "t2_b0_second");
    chk("t2_aw_n", aw_order.size(), 3);
    chk("t2_aw0", aw_order[0], 0);
    chk("t2_aw1", aw_order[1], 1);
    chk("t2_aw2", aw_order[2], 0);
    chk("t2_b_order1", b_order[1], 1);

    // W leads AW by three cycles on port 0.
    begin
      int ta, tw;
      ta = tgt_aw_cnt;
      tw = tgt_w_cnt;
      wr_req(0, 1'b1, 32'hA5A5A5A5, 4'hF, 1'b0, 1'b1);
      cyc();
      chk("t3_w_first", {dn_if.awvalid, dn_if.wvalid}, 2'b01);
      cyc();
      chk("t3_w_masked", {dn_if.wvalid, up_if.wready}, 3'b000);
      chk("t3_not_resp_a", dn_if.bready, 1'b0);
      cyc();
      up_if.awvalid[0] = 1'b1;
      #1;
      chk("t3_aw_late", dn_if.awvalid, 1'b1);
      chk("t3_not_resp_b", dn_if.bready, 1'b0);
      wait_b(0, 3, "t3_b0");
      chk("t3_one_aw", tgt_aw_cnt - ta, 1);
      chk("t3_one_w", tgt_w_cnt - tw, 1);
    end

    // Port 0 reads while port 1 writes.
    rd_req(0, 1'b0);
    wr_req(1, 1'b0, 32'h0BADF00D, 4'hF, 1'b1, 1'b1);
    wait_r(0, 1, "t4_r0");
    wait_b(1, 3, "t4_b1");
    chk("t4_rdata0", last_rdata[0], 32'h12345678);
    chk("t4_r_cnt1", r_cnt[1], 0);
    chk("t4_b_cnt0", b_cnt[0], 3);

    // R back-pressure on port 0 with a competing AR from port 1.
    ar_order.delete();
    up_if.rready[0] = 1'b0;
    rd_req(0, 1'b1);
    for (int k = 0; k < 50 && !up_if.rvalid[0]; k++) cyc();
    chk("t5_rvalid_seen", up_if.rvalid, 2'b01);
    rd_req(1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("t5_hold", {dn_if.rready, dn_if.rvalid, dn_if.arvalid, up_if.rvalid}, 5'b01001);
      cyc();
    end
    up_if.rready[0] = 1'b1;
    wait_r(0, 2, "t5_r0");
    wait_r(1, 1, "t5_r1");
    chk("t5_rdata0", last_rdata[0], 32'hCAFEF00D);
    chk("t5_rdata1", last_rdata[1], 32'h12345678);
    chk("t5_ar_n", ar_order.size(), 2);
    chk("t5_ar1", ar_order[1], 1);

    // Move both pointers to 1, then reset while port 1 sits in W_RESP.
    wr_req(0, 1'b0, 32'h44444444, 4'hF, 1'b1, 1'b1);
    rd_req(0, 1'b0);
    wait_b(0, 4, "t6_pre_b0");
    wait_r(0, 3, "t6_pre_r0");
    up_if.bready[1] = 1'b0;
    wr_req(1, 1'b1, 32'h77777777, 4'hF, 1'b1, 1'b1);
    for (int k = 0; k < 50 && !up_if.bvalid[1]; k++) cyc();
    chk("t6_in_resp", up_if.bvalid, 2'b10);
    areset = 1'b1;
    cyc();
    areset = 1'b0;
    chk("t6_rst_outs", all_hs, 15'h0);
    up_if.bready[1] = 1'b1;
    aw_order.delete();
    ar_order.delete();
    wr_req(0, 1'b0, 32'h55555555, 4'hF, 1'b1, 1'b1);
    wr_req(1, 1'b1, 32'h66666666, 4'hF, 1'b1, 1'b1);
    rd_req(0, 1'b1);
    rd_req(1, 1'b0);
    wait_b(0, 5, "t6_b0");
    wait_b(1, 4, "t6_b1");
    wait_r(0, 4, "t6_r0");
    wait_r(1, 2, "t6_r1");
    chk("t6_aw_first", aw_order[0], 0);
    chk("t6_ar_first", ar_order[0], 0);

    chk("nongranted_zero", leak, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
